// File: rtl/clock_pkg.sv
// Shared encodings, field widths and limits for the digital clock front panel.
// Imported by clock_field_editor and clock_mode_ctrl.
package clock_pkg;

    localparam int HOURS_W   = 5;
    localparam int MINS_W    = 6;
    localparam int SECS_W    = 6;
    localparam int HOURS_MAX = 23;
    localparam int MS_MAX    = 59;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_H = 2'd0,
        FIELD_M = 2'd1,
        FIELD_S = 2'd2
    } field_e;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:       return MODE_SET_TIME;
            MODE_SET_TIME:  return MODE_SET_ALARM;
            MODE_SET_ALARM: return MODE_STOPWATCH;
            default:        return MODE_RUN;
        endcase
    endfunction

    function automatic field_e next_field(input field_e f);
        case (f)
            FIELD_H: return FIELD_M;
            FIELD_M: return FIELD_S;
            default: return FIELD_H;
        endcase
    endfunction

    // Limit is checked before adding, so an out-of-range value can never be produced.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value >= max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/clock_field_editor.sv
// Hours/minutes/seconds register set with parallel load and a wrapping
// increment of the selected field; used for both the time edit and the alarm.
module clock_field_editor
    import clock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [HOURS_W-1:0] load_hours,
    input  logic [MINS_W-1:0]  load_mins,
    input  logic [SECS_W-1:0]  load_secs,
    input  logic               inc,
    input  field_e             field,
    output logic [HOURS_W-1:0] hours,
    output logic [MINS_W-1:0]  mins,
    output logic [SECS_W-1:0]  secs
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hours <= '0;
            mins  <= '0;
            secs  <= '0;
        end else if (load) begin
            hours <= load_hours;
            mins  <= load_mins;
            secs  <= load_secs;
        end else if (inc) begin
            case (field)
                FIELD_H: hours <= HOURS_W'(wrap_inc(6'(hours), 6'(HOURS_MAX)));
                FIELD_M: mins  <= MINS_W'(wrap_inc(6'(mins), 6'(MS_MAX)));
                FIELD_S: secs  <= SECS_W'(wrap_inc(6'(secs), 6'(MS_MAX)));
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel controller: mode sequencing, time/alarm field edits, stopwatch
// controls and the alarm buzzer. Optional snooze is built with CLOCK_SNOOZE_EN.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int BUZZ_SECS = 30
`ifdef CLOCK_SNOOZE_EN
    , parameter int SNOOZE_SECS = 300
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_mode,
    input  logic               btn_sel,
    input  logic               btn_inc,
    input  logic               tick_1hz,
    input  logic [HOURS_W-1:0] cur_hours,
    input  logic [MINS_W-1:0]  cur_mins,
    input  logic [SECS_W-1:0]  cur_secs,
    output logic [1:0]         mode,
    output logic [1:0]         field,
    output logic [HOURS_W-1:0] edit_hours,
    output logic [MINS_W-1:0]  edit_mins,
    output logic [SECS_W-1:0]  edit_secs,
    output logic               load_time,
    output logic               time_run,
    output logic [HOURS_W-1:0] alarm_hours,
    output logic [MINS_W-1:0]  alarm_mins,
    output logic [SECS_W-1:0]  alarm_secs,
    output logic               alarm_armed,
    output logic               sw_run,
    output logic               sw_clear,
    output logic               buzzer
);

    localparam int                BUZZ_W    = $clog2(BUZZ_SECS + 2);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_SECS);

    mode_e             mode_q, mode_d;
    field_e            field_q, field_d;
    logic              load_time_d, time_run_d, alarm_armed_d, sw_run_d, sw_clear_d;
    logic              buzzer_d;
    logic [BUZZ_W-1:0] buzz_cnt, buzz_cnt_d;
    logic              match, match_q, trigger, consumed, any_btn;
    logic              do_mode, do_sel, do_inc;
    logic              edit_load, edit_inc, alarm_inc;

`ifdef CLOCK_SNOOZE_EN
    localparam int                  SNOOZE_W    = $clog2(SNOOZE_SECS + 2);
    localparam logic [SNOOZE_W-1:0] SNOOZE_LOAD = SNOOZE_W'(SNOOZE_SECS);

    logic                snoozing, snoozing_d;
    logic [SNOOZE_W-1:0] snooze_cnt, snooze_cnt_d;
`endif

    assign mode  = mode_q;
    assign field = field_q;

    assign any_btn = btn_mode | btn_sel | btn_inc;
    assign match   = alarm_armed && (cur_hours == alarm_hours) &&
                     (cur_mins == alarm_mins) && (cur_secs == alarm_secs);
    assign trigger = match && !match_q &&
                     (mode_q != MODE_SET_TIME) && (mode_q != MODE_SET_ALARM);

    // A press that starts, cancels or snoozes the buzzer takes no other action.
`ifdef CLOCK_SNOOZE_EN
    assign consumed = trigger || buzzer || (snoozing && (btn_mode || btn_sel));
`else
    assign consumed = trigger || buzzer;
`endif

    assign do_mode = btn_mode && !consumed;
    assign do_sel  = btn_sel && !btn_mode && !consumed;
    assign do_inc  = btn_inc && !btn_mode && !btn_sel && !consumed;

    assign edit_load = do_mode && (mode_q == MODE_RUN);
    assign edit_inc  = do_inc && (mode_q == MODE_SET_TIME);
    assign alarm_inc = do_inc && (mode_q == MODE_SET_ALARM);

    clock_field_editor u_edit (
        .clk        (clk),
        .reset      (reset),
        .load       (edit_load),
        .load_hours (cur_hours),
        .load_mins  (cur_mins),
        .load_secs  (cur_secs),
        .inc        (edit_inc),
        .field      (field_q),
        .hours      (edit_hours),
        .mins       (edit_mins),
        .secs       (edit_secs)
    );

    clock_field_editor u_alarm (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b0),
        .load_hours ('0),
        .load_mins  ('0),
        .load_secs  ('0),
        .inc        (alarm_inc),
        .field      (field_q),
        .hours      (alarm_hours),
        .mins       (alarm_mins),
        .secs       (alarm_secs)
    );

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        mode_d        = mode_q;
        field_d       = field_q;
        load_time_d   = 1'b0;
        time_run_d    = time_run;
        alarm_armed_d = alarm_armed;
        sw_run_d      = sw_run;
        sw_clear_d    = 1'b0;

        if (do_mode) begin
            mode_d  = next_mode(mode_q);
            field_d = FIELD_H;
            case (mode_q)
                MODE_RUN:       time_run_d = 1'b0;
                MODE_SET_TIME: begin
                    load_time_d = 1'b1;
                    time_run_d  = 1'b1;
                end
                MODE_SET_ALARM: alarm_armed_d = 1'b1;
                default:        ;
            endcase
        end else if (do_sel) begin
            if (mode_q == MODE_SET_TIME || mode_q == MODE_SET_ALARM)
                field_d = next_field(field_q);
            else if (mode_q == MODE_STOPWATCH && !sw_run)
                sw_clear_d = 1'b1;
        end else if (do_inc && mode_q == MODE_STOPWATCH) begin
            sw_run_d = !sw_run;
        end
    end

`ifdef CLOCK_SNOOZE_EN
    always_comb begin
        buzzer_d     = buzzer;
        buzz_cnt_d   = buzz_cnt;
        snoozing_d   = snoozing;
        snooze_cnt_d = snooze_cnt;

        if (trigger) begin
            buzzer_d     = 1'b1;
            buzz_cnt_d   = BUZZ_LOAD;
            snoozing_d   = 1'b0;
            snooze_cnt_d = '0;
        end else if (buzzer) begin
            if (btn_inc && !btn_mode && !btn_sel) begin
                buzzer_d     = 1'b0;
                buzz_cnt_d   = '0;
                snoozing_d   = 1'b1;
                snooze_cnt_d = SNOOZE_LOAD;
            end else if (any_btn) begin
                buzzer_d   = 1'b0;
                buzz_cnt_d = '0;
            end else if (buzz_cnt == '0) begin
                buzzer_d = 1'b0;
            end else if (tick_1hz) begin
                buzz_cnt_d = buzz_cnt - BUZZ_W'(1);
            end
        end else if (snoozing) begin
            if (btn_mode || btn_sel) begin
                snoozing_d   = 1'b0;
                snooze_cnt_d = '0;
            end else if (snooze_cnt == '0) begin
                snoozing_d = 1'b0;
                buzzer_d   = 1'b1;
                buzz_cnt_d = BUZZ_LOAD;
            end else if (tick_1hz) begin
                snooze_cnt_d = snooze_cnt - SNOOZE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            snoozing   <= 1'b0;
            snooze_cnt <= '0;
        end else begin
            snoozing   <= snoozing_d;
            snooze_cnt <= snooze_cnt_d;
        end
    end
`else
    always_comb begin
        buzzer_d   = buzzer;
        buzz_cnt_d = buzz_cnt;

        if (trigger) begin
            buzzer_d   = 1'b1;
            buzz_cnt_d = BUZZ_LOAD;
        end else if (buzzer) begin
            if (any_btn) begin
                buzzer_d   = 1'b0;
                buzz_cnt_d = '0;
            end else if (buzz_cnt == '0) begin
                buzzer_d = 1'b0;
            end else if (tick_1hz) begin
                buzz_cnt_d = buzz_cnt - BUZZ_W'(1);
            end
        end
    end
`endif

    // Reset is synchronous: pending edits are simply dropped on the resetting edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q      <= MODE_RUN;
            field_q     <= FIELD_H;
            load_time   <= 1'b0;
            time_run    <= 1'b1;
            alarm_armed <= 1'b0;
            sw_run      <= 1'b0;
            sw_clear    <= 1'b0;
            buzzer      <= 1'b0;
            buzz_cnt    <= '0;
            match_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            field_q     <= field_d;
            load_time   <= load_time_d;
            time_run    <= time_run_d;
            alarm_armed <= alarm_armed_d;
            sw_run      <= sw_run_d;
            sw_clear    <= sw_clear_d;
            buzzer      <= buzzer_d;
            buzz_cnt    <= buzz_cnt_d;
            match_q     <= match;
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a behavioural model.
module tb_clock_mode_ctrl;

    localparam int BUZZ = 30;

    logic       clk;
    logic       reset;
    logic       btn_mode, btn_sel, btn_inc, tick_1hz;
    logic [4:0] cur_hours;
    logic [5:0] cur_mins, cur_secs;
    logic [1:0] mode, field;
    logic [4:0] edit_hours, alarm_hours;
    logic [5:0] edit_mins, edit_secs, alarm_mins, alarm_secs;
    logic       load_time, time_run, alarm_armed, sw_run, sw_clear, buzzer;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    clock_mode_ctrl #(.BUZZ_SECS(BUZZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_sel     (btn_sel),
        .btn_inc     (btn_inc),
        .tick_1hz    (tick_1hz),
        .cur_hours   (cur_hours),
        .cur_mins    (cur_mins),
        .cur_secs    (cur_secs),
        .mode        (mode),
        .field       (field),
        .edit_hours  (edit_hours),
        .edit_mins   (edit_mins),
        .edit_secs   (edit_secs),
        .load_time   (load_time),
        .time_run    (time_run),
        .alarm_hours (alarm_hours),
        .alarm_mins  (alarm_mins),
        .alarm_secs  (alarm_secs),
        .alarm_armed (alarm_armed),
        .sw_run      (sw_run),
        .sw_clear    (sw_clear),
        .buzzer      (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode as a counter mod 4, fields as an array with modular increments.
    int m_mode, m_field, m_left, m_btn;
    int m_edit[3];
    int m_alarm[3];
    int lim[3] = '{23, 59, 59};
    bit m_load, m_run, m_armed, m_swrun, m_swclr, m_buzz, m_prev, m_match, m_trig;

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_field = 0; m_left = 0;
            m_edit = '{0, 0, 0}; m_alarm = '{0, 0, 0};
            m_load = 0; m_run = 1; m_armed = 0; m_swrun = 0; m_swclr = 0;
            m_buzz = 0; m_prev = 0;
        end else begin
            m_btn   = btn_mode ? 1 : btn_sel ? 2 : btn_inc ? 3 : 0;
            m_match = m_armed && int'(cur_hours) == m_alarm[0] &&
                      int'(cur_mins) == m_alarm[1] && int'(cur_secs) == m_alarm[2];
            m_trig  = m_match && !m_prev && m_mode != 1 && m_mode != 2;
            m_prev  = m_match;
            m_load  = 0;
            m_swclr = 0;
            if (m_trig) begin
                m_buzz = 1;
                m_left = BUZZ;
            end else if (m_buzz) begin
                if (m_btn != 0) begin
                    m_buzz = 0;
                    m_left = 0;
                end else if (m_left == 0) m_buzz = 0;
                else if (tick_1hz) m_left = m_left - 1;
            end else begin
                case (m_btn)
                    1: begin
                        if (m_mode == 0) begin
                            m_edit = '{int'(cur_hours), int'(cur_mins), int'(cur_secs)};
                            m_run  = 0;
                        end else if (m_mode == 1) begin
                            m_load = 1;
                            m_run  = 1;
                        end else if (m_mode == 2) m_armed = 1;
                        m_mode  = (m_mode + 1) % 4;
                        m_field = 0;
                    end
                    2: begin
                        if (m_mode == 1 || m_mode == 2) m_field = (m_field + 1) % 3;
                        else if (m_mode == 3 && !m_swrun) m_swclr = 1;
                    end
                    3: begin
                        if (m_mode == 1)
                            m_edit[m_field] = (m_edit[m_field] + 1) % (lim[m_field] + 1);
                        else if (m_mode == 2)
                            m_alarm[m_field] = (m_alarm[m_field] + 1) % (lim[m_field] + 1);
                        else if (m_mode == 3) m_swrun = !m_swrun;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mode",        mode,        m_mode);
            check("field",       field,       m_field);
            check("edit_hours",  edit_hours,  m_edit[0]);
            check("edit_mins",   edit_mins,   m_edit[1]);
            check("edit_secs",   edit_secs,   m_edit[2]);
            check("load_time",   load_time,   m_load);
            check("time_run",    time_run,    m_run);
            check("alarm_hours", alarm_hours, m_alarm[0]);
            check("alarm_mins",  alarm_mins,  m_alarm[1]);
            check("alarm_secs",  alarm_secs,  m_alarm[2]);
            check("alarm_armed", alarm_armed, m_armed);
            check("sw_run",      sw_run,      m_swrun);
            check("sw_clear",    sw_clear,    m_swclr);
            check("buzzer",      buzzer,      m_buzz);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit m, input bit s, input bit i, input int n = 1);
        btn_mode = m; btn_sel = s; btn_inc = i;
        step(n);
        btn_mode = 0; btn_sel = 0; btn_inc = 0;
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        cur_hours = 5'(h); cur_mins = 6'(mi); cur_secs = 6'(s);
    endtask

    initial begin
        reset = 0; btn_mode = 0; btn_sel = 0; btn_inc = 0; tick_1hz = 0;
        set_cur(0, 0, 0);
        step(1);
        chk_en = 1;
        step(1);
        reset = 1;
        step(1);
        check("rst_mode", mode, 0);
        check("rst_time_run", time_run, 1);
        check("rst_buzzer", buzzer, 0);
        check("rst_armed", alarm_armed, 0);
        check("rst_alarm", {alarm_hours, alarm_mins, alarm_secs}, 0);

        // Time edit: 10:59:30 -> select M -> increment wraps 59 to 0.
        set_cur(10, 59, 30);
        press(1, 0, 0);
        check("st_mode", mode, 1);
        check("st_time_run", time_run, 0);
        check("st_edit_load", {edit_hours, edit_mins, edit_secs}, {5'd10, 6'd59, 6'd30});
        press(0, 1, 0);
        check("st_field", field, 1);
        press(0, 0, 1);
        check("st_edit_inc", {edit_hours, edit_mins, edit_secs}, {5'd10, 6'd0, 6'd30});
        press(1, 0, 0);
        check("st_load_time", load_time, 1);
        check("st_leave_mode", mode, 2);
        check("st_leave_run", time_run, 1);
        step(1);
        check("st_load_once", load_time, 0);

        // Alarm edit: wraps, then set 00:03:02.
        press(0, 0, 1, 25);
        check("sa_hours_wrap", alarm_hours, 1);
        press(0, 1, 0, 2);
        press(0, 0, 1, 60);
        check("sa_secs_wrap", alarm_secs, 0);
        press(0, 1, 0);
        press(0, 0, 1, 23);
        press(0, 1, 0);
        press(0, 0, 1, 3);
        press(0, 1, 0);
        press(0, 0, 1, 2);
        press(1, 0, 0);
        check("sa_armed", alarm_armed, 1);
        check("sa_alarm", {alarm_hours, alarm_mins, alarm_secs}, {5'd0, 6'd3, 6'd2});
        press(1, 0, 0);
        check("back_run", mode, 0);

        // Alarm match, 30 ticks of buzz, no retrigger while held.
        set_cur(0, 3, 2);
        step(1);
        check("buzz_on", buzzer, 1);
        for (int t = 0; t < BUZZ - 1; t++) begin
            tick_1hz = 1; step(1); tick_1hz = 0; step(1);
        end
        tick_1hz = 1; step(1); tick_1hz = 0;
        check("buzz_last_tick", buzzer, 1);
        step(1);
        check("buzz_off", buzzer, 0);
        step(3);
        check("no_retrigger", buzzer, 0);

        // Retrigger, then cancel with btn_mode (press consumed).
        set_cur(0, 3, 3);
        step(1);
        set_cur(0, 3, 2);
        step(1);
        check("retrigger", buzzer, 1);
        press(1, 0, 0);
        check("cancel_buzz", buzzer, 0);
        check("cancel_mode", mode, 0);

        // Stopwatch run/clear.
        set_cur(12, 0, 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        check("sw_mode", mode, 3);
        press(0, 0, 1);
        check("sw_start", sw_run, 1);
        press(0, 1, 0);
        check("sw_no_clear", sw_clear, 0);
        press(0, 0, 1);
        check("sw_stop", sw_run, 0);
        press(0, 1, 0);
        check("sw_clear_hi", sw_clear, 1);
        step(1);
        check("sw_clear_lo", sw_clear, 0);
        press(1, 0, 0);

        // Mode and inc together in SET_TIME: only the mode advance happens.
        set_cur(7, 45, 12);
        press(1, 0, 0);
        press(1, 0, 1);
        check("prio_mode", mode, 2);
        check("prio_edit", {edit_hours, edit_mins, edit_secs}, {5'd7, 6'd45, 6'd12});
        press(1, 0, 0); press(1, 0, 0);

        // Reset mid-edit discards the edit without a load strobe.
        press(1, 0, 0);
        press(0, 0, 1);
        check("mid_edit_hours", edit_hours, 8);
        reset = 0;
        step(1);
        reset = 1;
        check("mr_mode", mode, 0);
        check("mr_load", load_time, 0);
        check("mr_edit", edit_hours, 0);
        check("mr_run", time_run, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            reset    = ($urandom_range(0, 799) != 0);
            btn_mode = (r < 4);
            btn_sel  = (r >= 3 && r < 10);
            btn_inc  = (r >= 8 && r < 20);
            tick_1hz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    set_cur(m_alarm[0], m_alarm[1], m_alarm[2]);
                else
                    set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            end
            step(1);
        end
        reset = 1; btn_mode = 0; btn_sel = 0; btn_inc = 0; tick_1hz = 0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Front-panel controller for the digital clock datapath. It sequences the clock between four modes: run, time-set, alarm-set and stopwatch. It turns three debounced button pulses into field edits, load strobes and stopwatch run/clear controls, and it owns the alarm registers and the buzzer timer. It sits between the button debouncers and the clock timekeeping and stopwatch counters.

Parameters:
BUZZ_SECS, 30, number of tick_1hz pulses the buzzer stays on after an alarm match
SNOOZE_SECS, 300, re-ring delay in ticks (used only when CLOCK_SNOOZE_EN is defined)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
btn_mode  in  1  one-cycle pulse: advance to the next mode
btn_sel  in  1  one-cycle pulse: select the next field, or clear the stopwatch
btn_inc  in  1  one-cycle pulse: increment the selected field, or start/stop the stopwatch
tick_1hz  in  1  one-cycle pulse, once per second, from the prescaler
cur_hours  in  5  live hours from the timekeeper
cur_mins  in  6  live minutes
cur_secs  in  6  live seconds
mode  out  2  current mode: 0=RUN, 1=SET_TIME, 2=SET_ALARM, 3=STOPWATCH
field  out  2  selected field: 0=H, 1=M, 2=S
edit_hours/edit_mins/edit_secs  out  5/6/6  values to load into the timekeeper
load_time  out  1  one-cycle strobe; the timekeeper loads edit_* when it is high
time_run  out  1  timekeeper count enable
alarm_hours/alarm_mins/alarm_secs  out  5/6/6  stored alarm time
alarm_armed  out  1  alarm enabled
sw_run  out  1  stopwatch count enable
sw_clear  out  1  one-cycle stopwatch clear strobe
buzzer  out  1  buzzer drive

Behaviour:
- Reset values: mode=RUN, field=H, all edit_* and alarm_* =0, load_time=0, time_run=1, alarm_armed=0, sw_run=0, sw_clear=0, buzzer=0, buzz counter=0.
- Button priority: if several buttons pulse in the same cycle, only the highest-priority one is acted on (btn_mode > btn_sel > btn_inc). The others are dropped.
- Mode FSM: btn_mode steps RUN -> SET_TIME -> SET_ALARM -> STOPWATCH -> RUN. Each transition takes effect on the next clk edge. field resets to H on every mode entry.
- Entering SET_TIME (RUN -> SET_TIME edge):
  - edit_* <= cur_* in the same cycle.
  - time_run <= 0 from the next cycle.
- In SET_TIME:
  - btn_sel cycles field H -> M -> S -> H.
  - btn_inc increments the selected edit field, with wrap-around: hours 23 -> 0, mins/secs 59 -> 0. Other fields are unchanged.
- Leaving SET_TIME:
  - load_time=1 for exactly one cycle, registered and concurrent with mode becoming SET_ALARM.
  - time_run=1 in that same cycle.
  - Latency from the btn_mode pulse to load_time is 1 cycle.
- SET_ALARM: same field/inc rules, applied to alarm_* directly. Leaving it sets alarm_armed=1.
- STOPWATCH:
  - btn_inc toggles sw_run.
  - btn_sel pulses sw_clear for one cycle, but only while sw_run=0. It is ignored while the stopwatch runs.
- Leaving STOPWATCH: sw_run keeps its value, so the stopwatch counts in the background.
- Alarm match:
  - match = alarm_armed && cur_* == alarm_*, registered into match_q.
  - The alarm triggers on the rising edge of match (match && !match_q). It does not trigger while mode==SET_TIME or SET_ALARM.
  - On trigger: buzzer=1 and buzz counter=BUZZ_SECS.
  - While buzzing, each tick_1hz decrements the counter. buzzer drops in the cycle after the counter reaches 0.
- Buzz cancel: any button pulse while buzzer=1 sets buzzer=0 and counter=0. That press is consumed: no mode, field or stopwatch action.
- Simultaneous trigger and button: the trigger wins; the buzzer starts and the button is consumed.
- Arithmetic: every increment compares against its limit before adding, so no out-of-range value (hours>23, mins/secs>59) is ever stored.
- reset==0 at any time, including mid-edit or mid-buzz: all state returns to the reset values on that edge. Pending edits are discarded and no load_time is issued.

Optional Feature:
Macro CLOCK_SNOOZE_EN.
- When defined: btn_inc while buzzing snoozes instead of cancelling.
  - buzzer=0 and a snooze counter loads SNOOZE_SECS.
  - The counter decrements on tick_1hz. At 0 the buzzer re-rings for BUZZ_SECS.
  - btn_mode or btn_sel while buzzing, or during snooze, cancels both the buzz and the snooze.
- When not defined: no snooze counter exists, and every button cancels as above.

Decomposition:
- Package clock_pkg:
  - mode encodings MODE_RUN/SET_TIME/SET_ALARM/STOPWATCH
  - field encodings FIELD_H/M/S
  - widths HOURS_W=5, MINS_W=6, SECS_W=6
  - limits HOURS_MAX=23, MS_MAX=59
- Sub-module clock_field_editor: H/M/S registers with load, field select and wrapping increment. Instantiated twice, once for edit_* and once for alarm_*.

Test Plan:
- Reset held low 2 cycles, then released -> mode=0, time_run=1, buzzer=0, alarm_armed=0, all alarm_*=0.
- cur=10:59:30; btn_mode, btn_sel, btn_inc, btn_mode -> edit=10:00:30, load_time high for exactly 1 cycle, 1 cycle after the second btn_mode; mode=2; time_run=0 only while mode=1.
- In SET_ALARM: btn_inc x25 on H -> alarm_hours=1 (wrap at 23); sel to S, btn_inc x60 -> alarm_secs=0; leave -> alarm_armed=1.
- Alarm 00:03:02, cur steps to 00:03:02 in RUN -> buzzer=1 next cycle; 30 ticks later buzzer=0. Holding cur at the match value does not re-trigger.
- Buzzing, then btn_mode pulse -> buzzer=0 and mode unchanged. STOPWATCH: btn_inc -> sw_run=1; btn_sel -> no sw_clear; btn_inc, then btn_sel -> sw_clear one cycle.
- Buttons btn_mode and btn_inc in the same cycle in SET_TIME -> only the mode advance happens; edit_* unchanged.
